// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port memory bus arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output bus_resp_valid, bus_rdata,
        input  if_ack, dm_ack, rdata, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  bus_resp_valid, bus_rdata,
        output if_ack, dm_ack, rdata, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single 64-bit memory bus between instruction fetch and the data
// memory stage: DM has fixed priority, a starvation counter forces IF through.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave arb
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             if_ack_r, dm_ack_r, bus_req_r, bus_we_r;
    logic [63:0]      rdata_r, bus_addr_r, bus_wdata_r;
    logic             if_live_s, dm_first_s, grant_if_s, grant_dm_s;

    assign arb.if_ack    = if_ack_r;
    assign arb.dm_ack    = dm_ack_r;
    assign arb.rdata     = rdata_r;
    assign arb.bus_req   = bus_req_r;
    assign arb.bus_we    = bus_we_r;
    assign arb.bus_addr  = bus_addr_r;
    assign arb.bus_wdata = bus_wdata_r;

    // Arbitration, next state and starvation counter update
    always_comb begin
        if_live_s  = arb.if_req & ~if_ack_r;
        dm_first_s = arb.dm_req & (~arb.if_req | (cnt_r < LIMIT));
        grant_dm_s = 1'b0;
        grant_if_s = 1'b0;
        state_s    = state_r;
        cnt_s      = cnt_r;
        case (state_r)
            IDLE: begin
                // If DM has priority but is in its own ack cycle, its req is stale:
                // leave the bus idle rather than hand the slot down to IF.
                if (dm_first_s) begin
                    grant_dm_s = ~dm_ack_r;
                end else begin
                    grant_if_s = if_live_s;
                end
                if (grant_dm_s) begin
                    state_s = BUSY_DM;
                end else if (grant_if_s) begin
                    state_s = BUSY_IF;
                end else begin
                    state_s = IDLE;
                end
                if (grant_if_s || !arb.if_req) begin
                    cnt_s = '0;
                end else if (grant_dm_s && (cnt_r < LIMIT)) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (arb.bus_resp_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter, bus request registers and response routing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            rdata_r     <= 64'h0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 64'h0;
            bus_wdata_r <= 64'h0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_dm_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= arb.dm_we;
                        bus_addr_r  <= arb.dm_addr;
                        bus_wdata_r <= arb.dm_wdata;
                    end else if (grant_if_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= 1'b0;
                        bus_addr_r  <= arb.if_addr;
                        bus_wdata_r <= 64'h0;
                    end
                end
                BUSY_IF: begin
                    if (arb.bus_resp_valid) begin
                        rdata_r   <= arb.bus_rdata;
                        if_ack_r  <= 1'b1;
                        bus_req_r <= 1'b0;
                    end
                end
                BUSY_DM: begin
                    if (arb.bus_resp_valid) begin
                        if (!bus_we_r) begin
                            rdata_r <= arb.bus_rdata;
                        end
                        dm_ack_r  <= 1'b1;
                        bus_req_r <= 1'b0;
                    end
                end
                default: begin
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
